// File: rtl/param_data_memory.sv
// Line-organised data memory with a fixed request-to-ack latency.
// A request is latched in IDLE. A down-counter then paces it through WAIT.
// The access completes with a one-cycle ack in ACK.
// Addresses beyond the array raise err_o instead of touching the array.
// Read and write completions are tallied by saturating counters.
module param_data_memory #(
   parameter int LINE_W  = 256,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10,
   parameter int CNT_W   = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              err_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  rd_cnt_o,
   output logic [CNT_W-1:0]  wr_cnt_o
);

   localparam int OFFS  = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Line storage; deliberately has no reset so contents survive rst_i.
   logic [LINE_W-1:0] memory [0:DEPTH-1];

   state_t            state_r;
   state_t            state_s;
   logic [7:0]        lat_cnt_r;
   logic [7:0]        lat_cnt_s;
   logic              enter_ack_s;

   logic [ADDR_W-1:0] addr_r;
   logic [LINE_W-1:0] wdata_r;
   logic              write_r;

   logic [ADDR_W-1:0] req_addr_s;
   logic [LINE_W-1:0] req_data_s;
   logic              req_write_s;
   logic              in_range_s;
   logic [IDX_W-1:0]  idx_s;

   logic              ack_r;
   logic              err_r;
   logic              busy_r;
   logic [LINE_W-1:0] rdata_r;
   logic [CNT_W-1:0]  rd_cnt_r;
   logic [CNT_W-1:0]  wr_cnt_r;

   // Saturating increment for the statistics counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == {CNT_W{1'b1}}) begin
         sat_inc = value;
      end else begin
         sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // State register and latency counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r   <= IDLE;
         lat_cnt_r <= 8'd0;
      end else begin
         state_r   <= state_s;
         lat_cnt_r <= lat_cnt_s;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, single cycle in ACK.
   always_comb begin
      state_s     = state_r;
      lat_cnt_s   = lat_cnt_r;
      enter_ack_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable_i) begin
               lat_cnt_s = 8'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_s     = ACK;
                  enter_ack_s = 1'b1;
               end else begin
                  state_s = WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (lat_cnt_r == 8'd0) begin
               state_s     = ACK;
               enter_ack_s = 1'b1;
            end else begin
               lat_cnt_s = lat_cnt_r - 8'd1;
            end
         end
         ACK: begin
            state_s = IDLE;
         end
         default: begin
            state_s   = IDLE;
            lat_cnt_s = 8'd0;
         end
      endcase
   end

   // Request currently completing: live inputs when LATENCY=1 finishes on the accept edge.
   always_comb begin
      req_addr_s  = addr_r;
      req_data_s  = wdata_r;
      req_write_s = write_r;
      if (state_r == IDLE) begin
         req_addr_s  = addr_i;
         req_data_s  = data_i;
         req_write_s = write_i;
      end else begin
         req_addr_s  = addr_r;
         req_data_s  = wdata_r;
         req_write_s = write_r;
      end
      in_range_s = ((req_addr_s >> (OFFS + IDX_W)) == {ADDR_W{1'b0}});
      idx_s      = req_addr_s[OFFS +: IDX_W];
   end

   // Latch the request on the accept edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {LINE_W{1'b0}};
         write_r <= 1'b0;
      end else if ((state_r == IDLE) && enable_i) begin
         addr_r  <= addr_i;
         wdata_r <= data_i;
         write_r <= write_i;
      end
   end

   // Array write on the edge that enters ACK.
   always_ff @(posedge clk_i) begin
      if (rst_i && enter_ack_s && req_write_s && in_range_s) begin
         memory[idx_s] <= req_data_s;
      end
   end

   // Registered completion outputs and statistics.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
         rdata_r  <= {LINE_W{1'b0}};
         rd_cnt_r <= {CNT_W{1'b0}};
         wr_cnt_r <= {CNT_W{1'b0}};
      end else begin
         ack_r  <= enter_ack_s;
         err_r  <= enter_ack_s && !in_range_s;
         busy_r <= (state_s != IDLE);
         if (enter_ack_s && in_range_s && !req_write_s) begin
            rdata_r <= memory[idx_s];
         end else begin
            rdata_r <= {LINE_W{1'b0}};
         end
         if (enter_ack_s && in_range_s) begin
            if (req_write_s) begin
               wr_cnt_r <= sat_inc(wr_cnt_r);
            end else begin
               rd_cnt_r <= sat_inc(rd_cnt_r);
            end
         end
      end
   end

   assign ack_o    = ack_r;
   assign err_o    = err_r;
   assign busy_o   = busy_r;
   assign data_o   = rdata_r;
   assign rd_cnt_o = rd_cnt_r;
   assign wr_cnt_o = wr_cnt_r;

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory.
// dut_a uses the default parameters. dut_b uses LATENCY=1 and CNT_W=2.
module tb_param_data_memory;

   typedef struct {
      logic [255:0] data;
      logic         err;
      logic [15:0]  rd;
      logic [15:0]  wr;
      int           cyc;
   } exp_t;

   localparam logic [255:0] P1 = 256'h8888_8888_7777_7777_6666_6666_5555_5555_4444_4444_3333_3333_2222_2222_0000_0000;
   localparam logic [255:0] P3 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_0F0F_F0F0_F0F0_1111_2222_3333_4444;
   localparam logic [255:0] M0 = 256'hA5A5_A5A5_5A5A_5A5A_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0_0000_1111_2222_3333;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  a_addr = 32'd0;
   logic [255:0] a_din  = 256'd0;
   logic         a_en   = 1'b0;
   logic         a_wr   = 1'b0;
   logic         a_ack, a_err, a_busy;
   logic [255:0] a_dout;
   logic [15:0]  a_rd, a_wrc;
   logic [31:0]  b_addr = 32'd0;
   logic [255:0] b_din  = 256'd0;
   logic         b_en   = 1'b0;
   logic         b_wr   = 1'b0;
   logic         b_ack, b_err, b_busy;
   logic [255:0] b_dout;
   logic [1:0]   b_rd, b_wrc;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, e;

   param_data_memory dut_a (
      .clk_i(clk), .rst_i(rst_n), .addr_i(a_addr), .data_i(a_din), .enable_i(a_en),
      .write_i(a_wr), .ack_o(a_ack), .data_o(a_dout), .err_o(a_err), .busy_o(a_busy),
      .rd_cnt_o(a_rd), .wr_cnt_o(a_wrc)
   );

   param_data_memory #(.LATENCY(1), .CNT_W(2)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .addr_i(b_addr), .data_i(b_din), .enable_i(b_en),
      .write_i(b_wr), .ack_o(b_ack), .data_o(b_dout), .err_o(b_err), .busy_o(b_busy),
      .rd_cnt_o(b_rd), .wr_cnt_o(b_wrc)
   );

   always #5 clk = ~clk;

   // Edge counter: value after each rising edge is that edge's number.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop the scoreboard whenever either DUT acks.
   always @(negedge clk) begin
      if (a_ack) begin
         check("a_ack_one_cycle", {255'd0, prev_a}, 256'd0);
         if (qa.size() == 0) begin
            n_total++;
            $display("FAIL a_spurious_ack: ack at edge %0d with nothing outstanding", cyc);
         end else begin
            ea = qa.pop_front();
            check("a_data", a_dout, ea.data);
            check("a_err", {255'd0, a_err}, {255'd0, ea.err});
            check("a_rd_cnt", {240'd0, a_rd}, {240'd0, ea.rd});
            check("a_wr_cnt", {240'd0, a_wrc}, {240'd0, ea.wr});
            check("a_ack_edge", 256'(cyc), 256'(ea.cyc));
         end
      end
      if (b_ack) begin
         check("b_ack_one_cycle", {255'd0, prev_b}, 256'd0);
         if (qb.size() == 0) begin
            n_total++;
            $display("FAIL b_spurious_ack: ack at edge %0d with nothing outstanding", cyc);
         end else begin
            eb = qb.pop_front();
            check("b_data", b_dout, eb.data);
            check("b_err", {255'd0, b_err}, {255'd0, eb.err});
            check("b_rd_cnt", {254'd0, b_rd}, {240'd0, eb.rd});
            check("b_wr_cnt", {254'd0, b_wrc}, {240'd0, eb.wr});
            check("b_ack_edge", 256'(cyc), 256'(eb.cyc));
         end
      end
      prev_a <= a_ack;
      prev_b <= b_ack;
   end

   // Wait (bounded) until a queue drains, then one more negedge so the DUT is back in IDLE.
   task automatic drain(input bit which_b);
      int n;
      n = 0;
      while (((which_b ? qb.size() : qa.size()) != 0) && (n < 60)) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   // Single request on dut_a, issued at a negedge; expected ack 10 edges after accept.
   task automatic req_a(input logic [31:0] addr, input logic wr, input logic [255:0] d,
                        input logic [255:0] xd, input logic xerr, input int xrd, input int xwr);
      a_addr = addr;
      a_wr   = wr;
      a_din  = d;
      a_en   = 1'b1;
      @(posedge clk);
      #1;
      a_en  = 1'b0;
      e.data = xd; e.err = xerr; e.rd = 16'(xrd); e.wr = 16'(xwr); e.cyc = cyc + 10;
      qa.push_back(e);
      check("a_busy_after_accept", {255'd0, a_busy}, 256'd1);
      drain(1'b0);
   endtask

   initial begin
      int acc;
      rst_n = 1'b1;
      dut_a.memory[0] = M0;
      dut_a.memory[1] = P1;
      dut_b.memory[3] = P3;
      #1 rst_n = 1'b0;
      #1;
      check("rst_ack", {255'd0, a_ack}, 256'd0);
      check("rst_err", {255'd0, a_err}, 256'd0);
      check("rst_busy", {255'd0, a_busy}, 256'd0);
      check("rst_data", a_dout, 256'd0);
      check("rst_rd_cnt", {240'd0, a_rd}, 256'd0);
      check("rst_wr_cnt", {240'd0, a_wrc}, 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Preloaded read, issued in the same cycle reset is released.
      req_a(32'h20, 1'b0, 256'd0, P1, 1'b0, 1, 0);
      // Write then read back line 18.
      req_a(32'h240, 1'b1, {16{16'hECFA}}, 256'd0, 1'b0, 1, 1);
      req_a(32'h240, 1'b0, 256'd0, {16{16'hECFA}}, 1'b0, 2, 1);
      // Out-of-range read: error, zero data, counters untouched.
      req_a(32'h4000, 1'b0, 256'd0, 256'd0, 1'b1, 2, 1);

      // Requests toggled during WAIT are ignored; a held request is taken right after ACK.
      a_addr = 32'h20; a_wr = 1'b0; a_en = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      e.data = P1; e.err = 1'b0; e.rd = 16'd3; e.wr = 16'd1; e.cyc = acc + 10;
      qa.push_back(e);
      e.data = {16{16'hECFA}}; e.err = 1'b0; e.rd = 16'd4; e.wr = 16'd1; e.cyc = acc + 22;
      qa.push_back(e);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         a_en   = k[0];
         a_addr = k[0] ? 32'h240 : 32'h4000;
         a_wr   = 1'b1;
         a_din  = {256{1'b1}};
      end
      @(negedge clk);
      a_en = 1'b1; a_addr = 32'h240; a_wr = 1'b0; a_din = 256'd0;
      while (cyc < acc + 12) begin
         @(posedge clk);
         #1;
      end
      a_en = 1'b0;
      drain(1'b0);

      // Reset five cycles into a write: abandoned, array untouched, outputs cleared.
      a_addr = 32'h0; a_wr = 1'b1; a_din = {8{32'h1357_9BDF}}; a_en = 1'b1;
      @(posedge clk);
      #1;
      a_en = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_ack", {255'd0, a_ack}, 256'd0);
      check("mid_rst_err", {255'd0, a_err}, 256'd0);
      check("mid_rst_busy", {255'd0, a_busy}, 256'd0);
      check("mid_rst_data", a_dout, 256'd0);
      check("mid_rst_rd_cnt", {240'd0, a_rd}, 256'd0);
      check("mid_rst_wr_cnt", {240'd0, a_wrc}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("mem0_kept", dut_a.memory[0], M0);
      req_a(32'h0, 1'b0, 256'd0, M0, 1'b0, 1, 0);

      // LATENCY=1, CNT_W=2: five back-to-back reads, read count saturates at 3.
      b_addr = 32'h60; b_wr = 1'b0; b_en = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      for (int k = 0; k < 5; k++) begin
         e.data = P3; e.err = 1'b0; e.rd = (k < 2) ? 16'(k + 1) : 16'd3; e.wr = 16'd0;
         e.cyc  = acc + 2 * k;
         qb.push_back(e);
      end
      while (cyc < acc + 8) begin
         @(posedge clk);
         #1;
      end
      b_en = 1'b0;
      drain(1'b1);

      repeat (4) @(negedge clk);
      check("a_pending", 256'(qa.size()), 256'd0);
      check("b_pending", 256'(qb.size()), 256'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
